complex_coef_equalizer: RTL and testbench
=========================================

Name: complex_coef_equalizer

Overview:
Downstream consumer of the complex-inverse stage. It captures one sc16 coefficient (1/H, from the inverter output) and multiplies every sample of the following packet on the data stream by it. The product is rounded, clipped and re-emitted as sc16, which makes this the apply half of a one-tap frequency-domain equalizer in an RFNoC block chain. Fully AXI-stream handshaked on all ports, with backpressure.

Parameters:
SHIFT, 15, right-shift applied to full-precision products; 15 means the coefficient is Q1.15.
COEF_PER_PACKET, 1, 1 = consume exactly one coefficient before each sample packet; 0 = hold the last coefficient and accept a new one only at packet boundaries.

Ports:
clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous flush; same effect as reset on state and pipeline
c_tdata  in  32  coefficient, [31:16]=real a, [15:0]=imag b, signed int16
c_tlast  in  1  ignored
c_tvalid  in  1  coefficient valid
c_tready  out  1  coefficient accepted when c_tvalid&c_tready
i_tdata  in  32  sample, [31:16]=I, [15:0]=Q, signed int16
i_tlast  in  1  end of sample packet
i_tvalid  in  1  sample valid
i_tready  out  1  sample ready
o_tdata  out  32  equalized sample, [31:16]=real, [15:0]=imag
o_tlast  out  1  i_tlast delayed with its sample
o_tvalid  out  1  output valid
o_tready  in  1  downstream ready

Behaviour:
- States: LOAD (no usable coefficient) and RUN (coefficient held). Reset or clear forces LOAD, flushes all pipeline stages, drops the held coefficient and clears the mid_pkt flag.
- Reset values: o_tvalid=0, o_tdata=0, o_tlast=0, i_tready=0. c_tready is 0 while reset or clear is asserted and 1 from the first cycle after.
- LOAD: c_tready=1, i_tready=0. A coefficient handshake registers coef and moves to RUN.
- RUN: i_tready is 1 when pipeline stage 1 can advance. Each accepted sample sets mid_pkt; an accepted sample with i_tlast clears mid_pkt.
- COEF_PER_PACKET=1: acceptance of an i_tlast sample moves to LOAD; a single-sample packet (tlast on the first sample) is legal.
- COEF_PER_PACKET=0: stays in RUN. c_tready = !mid_pkt.
  - If c_tvalid and i_tvalid are both high at a boundary, the coefficient load wins and i_tready=0 that cycle.
  - The next sample uses the new coefficient.
- Coefficient changes never affect samples already accepted; each stage carries its own operands.
- Arithmetic:
  - re = I*a - Q*b; im = I*b + Q*a, computed in 33-bit signed.
  - Round: add 2^(SHIFT-1), then arithmetic-shift right by SHIFT (round half toward +inf).
  - Saturate to [-32768, 32767].
- Pipeline: 3 registered stages (multiply, add/round, shift/clip).
  - Latency: with o_tready held high, o_tvalid rises 3 cycles after the i_tvalid&i_tready cycle.
  - Throughput: 1 sample/clk.
- Backpressure: a stage advances when its successor is empty or advancing. With o_tready low the pipeline fills (3 samples) and then i_tready drops. No sample is lost or duplicated.
- o_tdata and o_tlast are held stable while o_tvalid&!o_tready.
- A clear mid-packet discards in-flight samples; the downstream sees a truncated packet with no tlast, by design.

Decomposition:
- Shared header/package: sc16 field positions (REAL_MSB=31, REAL_LSB=16, IMAG_MSB=15, IMAG_LSB=0), INT16_MAX/INT16_MIN constants, and LOAD/RUN state encodings.
- One sub-module: complex_mult_round_clip, the 3-stage elastic multiply/round/saturate pipeline with tdata/tlast/tvalid/tready, parameter SHIFT.
- The top level holds the FSM, the coefficient register and the mid_pkt logic.

Test Plan:
- Basic: coef (16384,0), packet of samples (1000,-2000),(−3,5) with tlast on the last -> outputs (500,-1000),(−1,3); o_tlast on the 2nd only; latency exactly 3 cycles.
- Rotation/rounding: coef (0,32767), sample (32767,0) -> (0,32766).
- Saturation: coef (-32768,0), sample (-32768,-32768) -> (32767,32767).
- COEF_PER_PACKET=1:
  - Two packets with no second coefficient -> i_tready=0 after the first tlast.
  - Supplying coef (0,-32768) then resumes; sample (100,0) -> (0,-100).
- Backpressure: o_tready random 50% over 64 samples with coef (32767,0) -> every output equals round(x*32767/32768); order and tlast preserved; i_tready low whenever 3 outputs are pending.
- COEF_PER_PACKET=0 and clear:
  - A coef offered mid-packet -> c_tready=0 until tlast accepted.
  - A simultaneous coef and sample at the boundary -> coef first, sample next cycle.
  - Asserting clear with 2 samples in flight -> o_tvalid=0 next cycle, state LOAD, c_tready=1.

Source files
------------

// File: rtl/complex_coef_equalizer_pkg.sv
// Shared definitions for the one-tap complex equalizer: sc16 field layout,
// int16 saturation limits and the coefficient FSM encoding.
package complex_coef_equalizer_pkg;

   localparam int REAL_MSB = 31;
   localparam int REAL_LSB = 16;
   localparam int IMAG_MSB = 15;
   localparam int IMAG_LSB = 0;

   localparam logic signed [15:0] INT16_MAX = 16'sh7fff;
   localparam logic signed [15:0] INT16_MIN = 16'sh8000;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [15:0] sat16(input logic signed [32:0] x);
      logic [15:0] r;
      if (x > 33'sd32767) begin
         r = INT16_MAX;
      end else if (x < -33'sd32768) begin
         r = INT16_MIN;
      end else begin
         r = x[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/complex_mult_round_clip.sv
// Three-stage elastic complex multiply / round / saturate pipeline. Every stage
// carries its own operands, so coefficient changes upstream never reach in-flight samples.
module complex_mult_round_clip
   import complex_coef_equalizer_pkg::*;
#(
   parameter int SHIFT = 15
) (
   input  logic        clk,
   input  logic        flush_i,
   input  logic [31:0] data_i,
   input  logic [31:0] coef_i,
   input  logic        last_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [31:0] data_o,
   output logic        last_o,
   output logic        valid_o,
   input  logic        ready_i
);

   localparam logic signed [32:0] ROUND = (SHIFT > 0) ? (33'sd1 <<< (SHIFT - 1)) : 33'sd0;

   logic signed [15:0] x_re, x_im, c_re, c_im;
   logic signed [31:0] ia_q, qb_q, ib_q, qa_q;
   logic signed [32:0] re_d, im_d, re_q, im_q, re_sh, im_sh;
   logic        [31:0] data_d, data_q;
   logic               valid1_q, valid2_q, valid3_q;
   logic               last1_q, last2_q, last3_q;
   logic               adv1, adv2, adv3;

   assign x_re = data_i[REAL_MSB:REAL_LSB];
   assign x_im = data_i[IMAG_MSB:IMAG_LSB];
   assign c_re = coef_i[REAL_MSB:REAL_LSB];
   assign c_im = coef_i[IMAG_MSB:IMAG_LSB];

   // A stage may load when it is empty or its contents move on this cycle.
   assign adv3 = !valid3_q || ready_i;
   assign adv2 = !valid2_q || adv3;
   assign adv1 = !valid1_q || adv2;

   assign re_d   = $signed({ia_q[31], ia_q}) - $signed({qb_q[31], qb_q}) + ROUND;
   assign im_d   = $signed({ib_q[31], ib_q}) + $signed({qa_q[31], qa_q}) + ROUND;
   assign re_sh  = re_q >>> SHIFT;
   assign im_sh  = im_q >>> SHIFT;
   assign data_d = {sat16(re_sh), sat16(im_sh)};

   always_ff @(posedge clk) begin
      if (flush_i) begin
         // NOTE: datapath registers are flushed as well so o_tdata reads 0 after reset or clear.
         valid1_q <= 1'b0;
         valid2_q <= 1'b0;
         valid3_q <= 1'b0;
         last1_q  <= 1'b0;
         last2_q  <= 1'b0;
         last3_q  <= 1'b0;
         ia_q     <= '0;
         qb_q     <= '0;
         ib_q     <= '0;
         qa_q     <= '0;
         re_q     <= '0;
         im_q     <= '0;
         data_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the previous cycle's values.
         if (adv1) begin
            valid1_q <= valid_i;
            if (valid_i) begin
               ia_q    <= 32'(x_re) * 32'(c_re);
               qb_q    <= 32'(x_im) * 32'(c_im);
               ib_q    <= 32'(x_re) * 32'(c_im);
               qa_q    <= 32'(x_im) * 32'(c_re);
               last1_q <= last_i;
            end
         end
         if (adv2) begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
               re_q    <= re_d;
               im_q    <= im_d;
               last2_q <= last1_q;
            end
         end
         if (adv3) begin
            valid3_q <= valid2_q;
            if (valid2_q) begin
               data_q  <= data_d;
               last3_q <= last2_q;
            end
         end
      end
   end

   assign ready_o = adv1;
   assign data_o  = data_q;
   assign last_o  = last3_q;
   assign valid_o = valid3_q;

endmodule

// File: rtl/complex_coef_equalizer.sv
// Apply half of a one-tap frequency-domain equalizer: captures a 1/H coefficient and
// multiplies each sample of the following packet by it.
module complex_coef_equalizer
   import complex_coef_equalizer_pkg::*;
#(
   parameter int SHIFT           = 15,
   parameter int COEF_PER_PACKET = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [31:0] c_tdata,
   input  logic        c_tlast,
   input  logic        c_tvalid,
   output logic        c_tready,
   input  logic [31:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready
);

   state_t      state_q, state_d;
   logic [31:0] coef_q, coef_d;
   logic        mid_pkt_q, mid_pkt_d;
   logic        flush, pipe_ready, c_fire, i_fire;
   logic        unused_c_tlast;

   assign flush          = reset || clear;
   assign unused_c_tlast = c_tlast;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d   = state_q;
      coef_d    = coef_q;
      mid_pkt_d = mid_pkt_q;
      c_tready  = 1'b0;
      i_tready  = 1'b0;

      if (!flush) begin
         case (state_q)
            LOAD: c_tready = 1'b1;
            RUN: begin
               c_tready = (COEF_PER_PACKET == 0) && !mid_pkt_q;
               // At a packet boundary a waiting coefficient takes priority over the next sample.
               i_tready = pipe_ready && !(c_tready && c_tvalid);
            end
            default: ;
         endcase
      end

      c_fire = c_tvalid && c_tready;
      i_fire = i_tvalid && i_tready;

      if (i_fire) begin
         mid_pkt_d = !i_tlast;
         if ((COEF_PER_PACKET != 0) && i_tlast) begin
            state_d = LOAD;
         end
      end
      if (c_fire) begin
         coef_d  = c_tdata;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state_q   <= LOAD;
         coef_q    <= '0;
         mid_pkt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         coef_q    <= coef_d;
         mid_pkt_q <= mid_pkt_d;
      end
   end

   complex_mult_round_clip #(
      .SHIFT(SHIFT)
   ) u_pipe (
      .clk     (clk),
      .flush_i (flush),
      .data_i  (i_tdata),
      .coef_i  (coef_q),
      .last_i  (i_tlast),
      .valid_i (i_fire),
      .ready_o (pipe_ready),
      .data_o  (o_tdata),
      .last_o  (o_tlast),
      .valid_o (o_tvalid),
      .ready_i (o_tready)
   );

endmodule

// File: tb/tb_complex_coef_equalizer.sv
// Self-checking bench: two equalizers (one coefficient per packet, and held coefficient)
// share stimulus; a behavioural model checks the selected one every cycle.
module tb_complex_coef_equalizer;

   logic        clk = 1'b0;
   logic        reset, clear;
   logic [31:0] c_tdata, i_tdata;
   logic        c_tlast, c_tvalid, i_tlast, i_tvalid, o_tready;
   int          ordy_mode;  // 0 low, 1 high, 2 random
   int          sel;        // 0: one coefficient per packet, 1: held coefficient

   logic [1:0]  c_tready_v, i_tready_v, o_tlast_v, o_tvalid_v;
   logic [31:0] o_tdata_v [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      complex_coef_equalizer #(
         .SHIFT(15),
         .COEF_PER_PACKET((g == 0) ? 1 : 0)
      ) dut (
         .clk      (clk),
         .reset    (reset),
         .clear    (clear),
         .c_tdata  (c_tdata),
         .c_tlast  (c_tlast),
         .c_tvalid (c_tvalid),
         .c_tready (c_tready_v[g]),
         .i_tdata  (i_tdata),
         .i_tlast  (i_tlast),
         .i_tvalid (i_tvalid),
         .i_tready (i_tready_v[g]),
         .o_tdata  (o_tdata_v[g]),
         .o_tlast  (o_tlast_v[g]),
         .o_tvalid (o_tvalid_v[g]),
         .o_tready (o_tready)
      );
   end

   logic        c_rdy, i_rdy, o_val, o_lst;
   logic [31:0] o_dat;
   assign c_rdy = c_tready_v[sel];
   assign i_rdy = i_tready_v[sel];
   assign o_val = o_tvalid_v[sel];
   assign o_lst = o_tlast_v[sel];
   assign o_dat = o_tdata_v[sel];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct { logic [31:0] data; logic last; int stamp; } exp_t;
   typedef struct { logic [31:0] data; logic last; int age; } obs_t;
   exp_t exp_q[$];
   obs_t obs_q[$];

   bit          have_coef = 1'b0;
   bit          mid = 1'b0;
   logic [31:0] coef_m = '0;
   logic        reset_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pk(input int re, input int im);
      return {re[15:0], im[15:0]};
   endfunction

   // Round half toward +inf by floor((x + 2^14) / 2^15), then clip to int16.
   function automatic longint rnd_clip(input longint x);
      longint y, q;
      y = x + 64'sd16384;
      q = y / 64'sd32768;
      if ((y % 64'sd32768 != 0) && (y < 0)) q = q - 1;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   function automatic logic [31:0] model_eq(input logic [31:0] s, input logic [31:0] c);
      longint xi, xq, ca, cb;
      xi = longint'($signed(s[31:16]));
      xq = longint'($signed(s[15:0]));
      ca = longint'($signed(c[31:16]));
      cb = longint'($signed(c[15:0]));
      return pk(int'(rnd_clip(xi * ca - xq * cb)), int'(rnd_clip(xi * cb + xq * ca)));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      o_tready = (ordy_mode == 2) ? 1'($urandom_range(0, 1)) : (ordy_mode == 1);
   end

   // Behavioural reference and per-cycle comparison against the selected DUT.
   always @(negedge clk) begin : model_b
      logic exp_c, exp_i, exp_v;
      bit   cpp;
      cpp = (sel == 0);
      if (reset || clear) begin
         check("c_tready_flush", c_rdy, 1'b0);
         check("i_tready_flush", i_rdy, 1'b0);
         if (reset && reset_prev) begin
            check("rst_o_tvalid", o_val, 1'b0);
            check("rst_o_tdata", o_dat, 32'h0);
            check("rst_o_tlast", o_lst, 1'b0);
         end
         exp_q.delete();
         have_coef = 1'b0;
         mid = 1'b0;
      end else begin
         exp_c = cpp ? !have_coef : !mid;
         exp_i = have_coef && !(!cpp && c_tvalid && exp_c) && ((exp_q.size() < 3) || o_tready);
         exp_v = (exp_q.size() > 0) && ((cyc - exp_q[0].stamp) >= 3);
         check("c_tready", c_rdy, exp_c);
         check("i_tready", i_rdy, exp_i);
         check("o_tvalid", o_val, exp_v);
         if (o_val && exp_q.size() > 0) begin
            check("o_tdata", o_dat, exp_q[0].data);
            check("o_tlast", o_lst, exp_q[0].last);
            if (o_tready) begin
               obs_q.push_back('{data: o_dat, last: o_lst, age: cyc - exp_q[0].stamp});
               void'(exp_q.pop_front());
            end
         end
         if (i_tvalid && i_rdy) begin
            exp_q.push_back('{data: model_eq(i_tdata, coef_m), last: i_tlast, stamp: cyc});
            mid = !i_tlast;
            if (cpp && i_tlast) have_coef = 1'b0;
         end
         if (c_tvalid && c_rdy) begin
            coef_m = c_tdata;
            have_coef = 1'b1;
         end
      end
      reset_prev = reset;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_coef(input int a, input int b);
      bit done;
      done = 1'b0;
      c_tdata = {a[15:0], b[15:0]};
      c_tvalid = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         done = c_rdy;
         step();
      end
      c_tvalid = 1'b0;
      check("coef_handshake_timeout", done, 1'b1);
   endtask

   task automatic send_sample(input int xi, input int xq, input bit last);
      bit done;
      done = 1'b0;
      i_tdata = {xi[15:0], xq[15:0]};
      i_tlast = last;
      i_tvalid = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         done = i_rdy;
         step();
      end
      i_tvalid = 1'b0;
      i_tlast = 1'b0;
      check("sample_handshake_timeout", done, 1'b1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic do_reset(input int which);
      reset = 1'b1;
      step();
      sel = which;
      repeat (2) step();
      reset = 1'b0;
      obs_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; clear = 1'b0; sel = 0; ordy_mode = 1; o_tready = 1'b1;
      c_tdata = '0; c_tlast = 1'b0; c_tvalid = 1'b0;
      i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
      repeat (3) step();
      reset = 1'b0;

      // Reset state, first cycle after release
      @(negedge clk);
      check("post_rst_c_tready", c_rdy, 1'b1);
      check("post_rst_i_tready", i_rdy, 1'b0);
      check("post_rst_o_tvalid", o_val, 1'b0);
      step();

      // Basic packet with latency check
      send_coef(16384, 0);
      send_sample(1000, -2000, 1'b0);
      send_sample(-3, 5, 1'b1);
      drain();
      check("basic_count", obs_q.size(), 2);
      check("basic0_data", obs_q[0].data, pk(500, -1000));
      check("basic0_last", obs_q[0].last, 1'b0);
      check("basic0_latency", obs_q[0].age, 3);
      check("basic1_data", obs_q[1].data, pk(-1, 3));
      check("basic1_last", obs_q[1].last, 1'b1);
      check("basic1_latency", obs_q[1].age, 3);

      // Second packet without a new coefficient must stall
      i_tdata = pk(7, 7); i_tlast = 1'b1; i_tvalid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("stall_i_tready", i_rdy, 1'b0);
         step();
      end
      i_tvalid = 1'b0; i_tlast = 1'b0;
      obs_q.delete();
      send_coef(0, -32768);
      send_sample(100, 0, 1'b1);
      drain();
      check("resume_data", obs_q[0].data, pk(0, -100));

      // Rotation with rounding, then saturation
      obs_q.delete();
      send_coef(0, 32767);
      send_sample(32767, 0, 1'b1);
      send_coef(-32768, 0);
      send_sample(-32768, -32768, 1'b1);
      drain();
      check("rotate_data", obs_q[0].data, pk(0, 32766));
      check("saturate_data", obs_q[1].data, pk(32767, 32767));

      // Random backpressure over a 64-sample packet
      obs_q.delete();
      send_coef(32767, 0);
      ordy_mode = 2;
      for (int k = 0; k < 64; k++) begin
         send_sample(int'($urandom), int'($urandom), k == 63);
      end
      drain();
      ordy_mode = 1;
      step();
      check("bp_count", obs_q.size(), 64);
      check("bp_last_flag", obs_q[63].last, 1'b1);

      // Held-coefficient instance: mid-packet coefficient waits for tlast
      do_reset(1);
      send_coef(16384, 0);
      send_sample(10, 20, 1'b0);
      fork
         send_coef(0, 16384);
         begin
            send_sample(30, 40, 1'b0);
            send_sample(50, 60, 1'b1);
         end
      join
      send_sample(100, 0, 1'b1);
      drain();
      check("hold_count", obs_q.size(), 4);
      check("hold_old_coef", obs_q[2].data, pk(25, 30));
      check("hold_new_coef", obs_q[3].data, pk(0, 50));

      // Coefficient and sample together at a boundary: coefficient first
      obs_q.delete();
      fork
         send_coef(16384, 0);
         send_sample(8, 8, 1'b1);
      join
      drain();
      check("boundary_data", obs_q[0].data, pk(4, 4));

      // Clear with two samples in flight
      ordy_mode = 0;
      step();
      send_sample(1, 1, 1'b0);
      send_sample(2, 2, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      @(negedge clk);
      check("clear_o_tvalid", o_val, 1'b0);
      check("clear_c_tready", c_rdy, 1'b1);
      check("clear_i_tready", i_rdy, 1'b0);
      step();
      ordy_mode = 1;
      step();
      obs_q.delete();
      send_coef(16384, 0);
      send_sample(-9, 9, 1'b1);
      drain();
      check("after_clear_count", obs_q.size(), 1);
      check("after_clear_data", obs_q[0].data, pk(-4, 5));

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
